in_port_buffer: RTL and testbench

//  Buffered, parametrised input port for the Datapath; successor of the single-register in-port.

---
 rtl/io_port_pkg.sv | 8 +
 rtl/in_port_fifo.sv | 51 +++++
 rtl/in_port_buffer.sv | 103 ++++++++++
 tb/tb_in_port_buffer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
// Shared constants for the Datapath I/O ports: buffering modes and bus width.
package io_port_pkg;

  localparam int MODE_LATCH = 0;
  localparam int MODE_FIFO  = 1;
  localparam int BUS_WIDTH  = 32;

endpackage

// File: rtl/in_port_fifo.sv
// DEPTH-entry circular buffer with an occupancy counter; the caller guarantees
// that push never happens when full and pop never happens when empty.
module in_port_fifo
  import io_port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign head = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      // NOTE: the storage array is cleared on purpose so a stale word can
      // never reach the bus after reset; this forces flops instead of RAM.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/in_port_buffer.sv
// Buffered CPU input port: valid/ready device side, pop-on-read CPU side,
// latch or FIFO storage, sticky overflow/underflow flags.
module in_port_buffer
  import io_port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int MODE  = MODE_FIFO
) (
  input  logic                         Clock,
  input  logic                         Clear,
  input  logic [WIDTH-1:0]             Ext_data,
  input  logic                         Ext_valid,
  output logic                         Ext_ready,
  input  logic                         InPortout,
  input  logic                         Clear_flags,
  output logic [BUS_WIDTH-1:0]         BusMuxIn_InPort,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Empty,
  output logic                         Full,
  output logic                         Overflow,
  output logic                         Underflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = (MODE == MODE_FIFO) ? CW'(DEPTH) : CW'(1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_word;
  logic [CW-1:0]    count_q;
  logic             ovf_set;
  logic             unf_set;

  assign Count = count_q;
  assign Empty = (count_q == '0);
  assign Full  = (count_q == FULL_COUNT);

  // FIFO refuses on registered fullness only; latch always takes the word.
  assign Ext_ready = (MODE == MODE_FIFO) ? ~Full : 1'b1;
  assign push      = Ext_valid & Ext_ready;
  assign pop       = InPortout & ~Empty;

  generate
    if (MODE == MODE_FIFO) begin : g_fifo
      in_port_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (Clock),
        .clear (Clear),
        .push  (push),
        .pop   (pop),
        .wdata (Ext_data),
        .head  (head_word),
        .count (count_q)
      );
    end else begin : g_latch
      logic [WIDTH-1:0] latch_data;
      logic             latch_valid;

      always_ff @(posedge Clock) begin
        if (Clear) begin
          latch_data  <= '0;
          latch_valid <= 1'b0;
        end else if (push) begin
          latch_data  <= Ext_data;
          latch_valid <= 1'b1;
        end else if (pop) begin
          latch_valid <= 1'b0;
        end
      end

      assign head_word = latch_data;
      assign count_q   = CW'(latch_valid);
    end
  endgenerate

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ovf_set = 1'b0;
    unf_set = InPortout & Empty;
    if (MODE == MODE_FIFO) ovf_set = Ext_valid & Full;
    else                   ovf_set = push & Full & ~pop;
  end

  // Set events take priority over Clear_flags in the same cycle.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      if (ovf_set)          Overflow <= 1'b1;
      else if (Clear_flags) Overflow <= 1'b0;
      if (unf_set)          Underflow <= 1'b1;
      else if (Clear_flags) Underflow <= 1'b0;
    end
  end

  assign BusMuxIn_InPort = Empty ? '0 : BUS_WIDTH'(head_word);

endmodule

// File: tb/tb_in_port_buffer.sv
// Directed bench for in_port_buffer: one FIFO instance (8x4) and one latch
// instance (16-bit), expected values written out by hand.
module tb_in_port_buffer;
  import io_port_pkg::*;

  logic clk;
  logic clear;

  logic [7:0]  f_data;
  logic        f_valid, f_rd, f_cf;
  logic        f_ready, f_empty, f_full, f_ovf, f_unf;
  logic [31:0] f_bus;
  logic [2:0]  f_count;

  logic [15:0] l_data;
  logic        l_valid, l_rd, l_cf;
  logic        l_ready, l_empty, l_full, l_ovf, l_unf;
  logic [31:0] l_bus;
  logic [2:0]  l_count;

  int n_checks = 0;
  int n_pass   = 0;

  in_port_buffer #(.WIDTH(8), .DEPTH(4), .MODE(MODE_FIFO)) u_fifo_port (
    .Clock           (clk),
    .Clear           (clear),
    .Ext_data        (f_data),
    .Ext_valid       (f_valid),
    .Ext_ready       (f_ready),
    .InPortout       (f_rd),
    .Clear_flags     (f_cf),
    .BusMuxIn_InPort (f_bus),
    .Count           (f_count),
    .Empty           (f_empty),
    .Full            (f_full),
    .Overflow        (f_ovf),
    .Underflow       (f_unf)
  );

  in_port_buffer #(.WIDTH(16), .DEPTH(4), .MODE(MODE_LATCH)) u_latch_port (
    .Clock           (clk),
    .Clear           (clear),
    .Ext_data        (l_data),
    .Ext_valid       (l_valid),
    .Ext_ready       (l_ready),
    .InPortout       (l_rd),
    .Clear_flags     (l_cf),
    .BusMuxIn_InPort (l_bus),
    .Count           (l_count),
    .Empty           (l_empty),
    .Full            (l_full),
    .Overflow        (l_ovf),
    .Underflow       (l_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic f_push(input logic [7:0] v);
    f_data = v; f_valid = 1'b1;
    tick();
    f_valid = 1'b0;
  endtask

  task automatic f_pop(input string tag, input logic [31:0] exp);
    check(tag, f_bus, exp);
    f_rd = 1'b1;
    tick();
    f_rd = 1'b0;
  endtask

  initial begin
    clear = 1'b1;
    f_data = 8'h99; f_valid = 1'b1; f_rd = 1'b0; f_cf = 1'b0;
    l_data = 16'h0; l_valid = 1'b0; l_rd = 1'b0; l_cf = 1'b0;

    // 1: reset with a handshake offered
    tick();
    check("rst_count", 32'(f_count), 32'd0);
    check("rst_empty", 32'(f_empty), 32'd1);
    check("rst_full",  32'(f_full),  32'd0);
    check("rst_ready", 32'(f_ready), 32'd1);
    check("rst_bus",   f_bus,        32'h0);
    check("rst_ovf",   32'(f_ovf),   32'd0);
    check("rst_unf",   32'(f_unf),   32'd0);
    check("rst_l_bus", l_bus,        32'h0);
    clear = 1'b0; f_valid = 1'b0;
    tick();
    check("rst_hold_count", 32'(f_count), 32'd0);

    // 2: FIFO ordering
    f_push(8'h11); f_push(8'h22); f_push(8'h33); f_push(8'h44);
    check("fill_full",  32'(f_full),  32'd1);
    check("fill_ready", 32'(f_ready), 32'd0);
    check("fill_count", 32'(f_count), 32'd4);
    f_pop("order0", 32'h11);
    f_pop("order1", 32'h22);
    f_pop("order2", 32'h33);
    f_pop("order3", 32'h44);
    check("drain_empty", 32'(f_empty), 32'd1);
    check("drain_bus",   f_bus,        32'h0);
    check("drain_ovf",   32'(f_ovf),   32'd0);

    // 3: push refused while full even with a same-cycle pop
    f_push(8'h11); f_push(8'h22); f_push(8'h33); f_push(8'h44);
    f_data = 8'h55; f_valid = 1'b1; f_rd = 1'b1;
    tick();
    f_rd = 1'b0;
    check("full_pop_count", 32'(f_count), 32'd3);
    check("full_pop_ovf",   32'(f_ovf),   32'd1);
    check("full_pop_head",  f_bus,        32'h22);
    check("full_pop_ready", 32'(f_ready), 32'd1);
    tick();
    f_valid = 1'b0;
    check("retry_count", 32'(f_count), 32'd4);
    f_pop("retry0", 32'h22);
    f_pop("retry1", 32'h33);
    f_pop("retry2", 32'h44);
    f_pop("retry3", 32'h55);
    check("retry_empty", 32'(f_empty), 32'd1);
    f_cf = 1'b1;
    tick();
    f_cf = 1'b0;
    check("cf_ovf", 32'(f_ovf), 32'd0);

    // 4: pointer wrap with interleaved push/pop
    f_push(8'hA0);
    for (int i = 1; i < 10; i++) begin
      check($sformatf("wrap_head%0d", i - 1), f_bus, 32'(8'hA0 + i - 1));
      f_data = 8'(8'hA0 + i); f_valid = 1'b1; f_rd = 1'b1;
      tick();
      check($sformatf("wrap_count%0d", i), 32'(f_count), 32'd1);
    end
    f_valid = 1'b0; f_rd = 1'b0;
    f_pop("wrap_last", 32'hA9);
    check("wrap_empty", 32'(f_empty), 32'd1);
    check("wrap_ovf",   32'(f_ovf),   32'd0);

    // 5: underflow and flag-clear priority
    f_rd = 1'b1;
    tick();
    f_rd = 1'b0;
    check("unf_bus",   f_bus,        32'h0);
    check("unf_set",   32'(f_unf),   32'd1);
    check("unf_count", 32'(f_count), 32'd0);
    f_cf = 1'b1;
    tick();
    check("unf_cleared", 32'(f_unf), 32'd0);
    f_rd = 1'b1;
    tick();
    f_rd = 1'b0; f_cf = 1'b0;
    check("unf_set_wins", 32'(f_unf), 32'd1);
    f_data = 8'h77; f_valid = 1'b1; f_rd = 1'b1;
    tick();
    f_valid = 1'b0; f_rd = 1'b0;
    check("empty_pp_count", 32'(f_count), 32'd1);
    check("empty_pp_bus",   f_bus,        32'h77);
    check("empty_pp_unf",   32'(f_unf),   32'd1);

    // 6: latch mode overwrite, push+pop, and reset mid-burst
    l_data = 16'h1234; l_valid = 1'b1;
    tick();
    check("l_first_bus",   l_bus,        32'h1234);
    check("l_first_full",  32'(l_full),  32'd1);
    check("l_first_ovf",   32'(l_ovf),   32'd0);
    check("l_ready_full",  32'(l_ready), 32'd1);
    l_data = 16'hBEEF;
    tick();
    check("l_over_bus",   l_bus,        32'h0000BEEF);
    check("l_over_ovf",   32'(l_ovf),   32'd1);
    check("l_over_count", 32'(l_count), 32'd1);
    l_data = 16'hCAFE; l_rd = 1'b1;
    tick();
    l_rd = 1'b0;
    check("l_pp_count", 32'(l_count), 32'd1);
    check("l_pp_bus",   l_bus,        32'h0000CAFE);
    l_data = 16'h5555; clear = 1'b1;
    tick();
    clear = 1'b0; l_valid = 1'b0;
    check("l_clr_count", 32'(l_count), 32'd0);
    check("l_clr_bus",   l_bus,        32'h0);
    check("l_clr_empty", 32'(l_empty), 32'd1);
    check("l_clr_ovf",   32'(l_ovf),   32'd0);
    check("f_clr_count", 32'(f_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
